// File: rtl/execute_stage.sv
// RV32I execute stage: ALU, BEQ/JAL redirect, EX/MEM pipeline register and redirect counter.
// Optional operand forwarding from MEM/WB is enabled by defining FWD_EN.
module execute_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteE,
  input  logic              MemWriteE,
  input  logic              JumpE,
  input  logic              BranchE,
  input  logic              ALUSrcE,
  input  logic [1:0]        ResultSrcE,
  input  logic [2:0]        ALU_CtrlE,
  input  logic [XLEN-1:0]   RD1_E,
  input  logic [XLEN-1:0]   RD2_E,
  input  logic [XLEN-1:0]   PCE,
  input  logic [XLEN-1:0]   Imm_ExtE,
  input  logic [XLEN-1:0]   PCPlus4E,
  input  logic [4:0]        RdE,
  input  logic [XLEN-1:0]   ALUResultW_fwd,
  input  logic [XLEN-1:0]   ResultW_fwd,
  input  logic [1:0]        ForwardAE,
  input  logic [1:0]        ForwardBE,
  output logic              PCSrcE,
  output logic [XLEN-1:0]   PCTargetE,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic [1:0]        ResultSrcM,
  output logic [XLEN-1:0]   ALUResultM,
  output logic [XLEN-1:0]   WriteDataM,
  output logic [4:0]        RdM,
  output logic [XLEN-1:0]   PCPlus4M,
  output logic [CNT_W-1:0]  RedirectCnt
);

  logic [XLEN-1:0]  op_a_s;
  logic [XLEN-1:0]  op_b_s;
  logic [XLEN-1:0]  src_b_s;
  logic [XLEN-1:0]  alu_res_s;
  logic             zero_s;

  logic             reg_write_q, reg_write_d;
  logic             mem_write_q, mem_write_d;
  logic [1:0]       result_src_q, result_src_d;
  logic [XLEN-1:0]  alu_result_q, alu_result_d;
  logic [XLEN-1:0]  write_data_q, write_data_d;
  logic [4:0]       rd_q, rd_d;
  logic [XLEN-1:0]  pc_plus4_q, pc_plus4_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef FWD_EN
  // Forwarding muxes ahead of the ALUSrc mux; select 11 falls back to the register file value.
  always_comb begin
    op_a_s = RD1_E;
    op_b_s = RD2_E;
    case (ForwardAE)
      2'b01:   op_a_s = ResultW_fwd;
      2'b10:   op_a_s = ALUResultW_fwd;
      default: op_a_s = RD1_E;
    endcase
    case (ForwardBE)
      2'b01:   op_b_s = ResultW_fwd;
      2'b10:   op_b_s = ALUResultW_fwd;
      default: op_b_s = RD2_E;
    endcase
  end
`else
  logic unused_fwd_s;
  assign unused_fwd_s = ^{ALUResultW_fwd, ResultW_fwd, ForwardAE, ForwardBE};
  assign op_a_s       = RD1_E;
  assign op_b_s       = RD2_E;
`endif

  assign src_b_s = ALUSrcE ? Imm_ExtE : op_b_s;

  // ALU; all arithmetic wraps modulo 2^XLEN.
  always_comb begin
    alu_res_s = {XLEN{1'b0}};
    case (ALU_CtrlE)
      3'b000:  alu_res_s = op_a_s + src_b_s;
      3'b001:  alu_res_s = op_a_s - src_b_s;
      3'b010:  alu_res_s = op_a_s & src_b_s;
      3'b011:  alu_res_s = op_a_s | src_b_s;
      3'b100:  alu_res_s = op_a_s ^ src_b_s;
      3'b101:  alu_res_s = ($signed(op_a_s) < $signed(src_b_s)) ?
                           {{(XLEN-1){1'b0}}, 1'b1} : {XLEN{1'b0}};
      3'b110:  alu_res_s = op_a_s << src_b_s[4:0];
      3'b111:  alu_res_s = op_a_s >> src_b_s[4:0];
      default: alu_res_s = {XLEN{1'b0}};
    endcase
  end

  assign zero_s    = (alu_res_s == {XLEN{1'b0}});
  assign PCSrcE    = (BranchE & zero_s) | JumpE;
  assign PCTargetE = PCE + Imm_ExtE;

  // Next-state values for the EX/MEM register and redirect counter.
  always_comb begin
    reg_write_d  = RegWriteE;
    mem_write_d  = MemWriteE;
    result_src_d = ResultSrcE;
    alu_result_d = alu_res_s;
    write_data_d = op_b_s;
    rd_d         = RdE;
    pc_plus4_d   = PCPlus4E;
    if (PCSrcE) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // EX/MEM register; synchronous reset wins over load and count.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= 2'b00;
      alu_result_q <= {XLEN{1'b0}};
      write_data_q <= {XLEN{1'b0}};
      rd_q         <= 5'd0;
      pc_plus4_q   <= {XLEN{1'b0}};
      cnt_q        <= {CNT_W{1'b0}};
    end else begin
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      result_src_q <= result_src_d;
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      rd_q         <= rd_d;
      pc_plus4_q   <= pc_plus4_d;
      cnt_q        <= cnt_d;
    end
  end

  assign RegWriteM   = reg_write_q;
  assign MemWriteM   = mem_write_q;
  assign ResultSrcM  = result_src_q;
  assign ALUResultM  = alu_result_q;
  assign WriteDataM  = write_data_q;
  assign RdM         = rd_q;
  assign PCPlus4M    = pc_plus4_q;
  assign RedirectCnt = cnt_q;

endmodule
